// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one fetch outstanding on the
// instruction memory port and presents {pc, inst, valid} to the IF/ID register.
module if_fetch_stage #(
   parameter int                 ADDR_W   = 64,
   parameter int                 INST_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [INST_W-1:0] imem_rdata_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic              valid_o
);

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                drop_q, drop_d;
   logic [ADDR_W-1:0]   pcOut_q, pcOut_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic                valid_q, valid_d;
   logic [ADDR_W-1:0]   redirTarget;

   assign redirTarget = {redirect_pc_i[ADDR_W-1:2], 2'b00};

   // Next-state logic; a redirect overrides hold and response handling. drop_q marks
   // the outstanding fetch as stale so its response is swallowed when it arrives.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      pcOut_d = pcOut_q;
      inst_d  = inst_q;
      valid_d = valid_q;
      unique case (state_q)
         S_RST: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            if (imem_gnt_i) begin
               state_d = S_WAIT;
               drop_d  = redirect_i;
            end
            if (redirect_i) begin
               pc_d    = redirTarget;
               valid_d = 1'b0;
            end
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               if (drop_q || redirect_i) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  pcOut_d = pc_q;
                  inst_d  = imem_rdata_i;
                  valid_d = 1'b1;
                  state_d = S_OUT;
               end
            end else if (redirect_i) begin
               drop_d = 1'b1;
            end
            if (redirect_i) begin
               pc_d    = redirTarget;
               valid_d = 1'b0;
            end
         end
         S_OUT: begin
            if (redirect_i) begin
               pc_d    = redirTarget;
               valid_d = 1'b0;
               state_d = S_REQ;
            end else if (!hold_i) begin
               pc_d    = pc_q + ADDR_W'(4);
               valid_d = 1'b0;
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_RST;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RST;
         pc_q    <= RESET_PC;
         drop_q  <= 1'b0;
         pcOut_q <= '0;
         inst_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         pcOut_q <= pcOut_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
      end
   end

   assign imem_req_o  = (state_q == S_REQ);
   assign imem_addr_o = pc_q;
   assign pc_o        = pcOut_q;
   assign inst_o      = inst_q;
   assign valid_o     = valid_q;

endmodule
